// File: rtl/trn_word_serializer.sv
// trn_word_serializer
//   Captures a WORD_W-bit result on a data_valid strobe and streams it as
//   ceil(WORD_W/8) bytes to a UART transmitter over the TxD_start/TxD_busy
//   handshake. MSB_FIRST selects the byte order. A start that is never
//   acknowledged by TxD_busy is written off after ACK_TIMEOUT cycles.
//   Strobes that arrive while a word is in flight are dropped and flagged.
//   Optional feature macro: TRN_HEADER_EN -- when defined, every word is
//   preceded by HEADER_BYTE.
module trn_word_serializer #(
  parameter int         WORD_W      = 16,
  parameter int         MSB_FIRST   = 0,
  parameter int         ACK_TIMEOUT = 15,
  parameter logic [7:0] HEADER_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] data_in,
  input  logic              data_valid,
  output logic              in_ready,
  input  logic              TxD_busy,
  output logic              TxD_start,
  output logic [7:0]        TxD_data,
  output logic              word_done,
  output logic              overrun,
  output logic              overrun_sticky
);

  localparam int NBYTES = (WORD_W + 7) / 8;
  localparam int PAD_W  = NBYTES * 8;
`ifdef TRN_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int NSLOTS = NBYTES + HDR;
  localparam int IDX_W  = $clog2(NBYTES + 1);
  localparam int CNT_W  = $clog2(ACK_TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLOTS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_WAIT_FREE = 3'd2,
    S_START     = 3'd3,
    S_WAIT_ACK  = 3'd4,
    S_WAIT_DONE = 3'd5,
    S_NEXT      = 3'd6
  } state_t;

  state_t           state;
  logic [PAD_W-1:0] hold;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;

  // Byte for a transmit slot: slot 0 is the header when one is configured,
  // the remaining slots walk the zero-padded word in the configured order.
  function automatic logic [7:0] pick_byte(input logic [PAD_W-1:0] word,
                                           input logic [IDX_W-1:0] slot);
    int         pos;
    logic [7:0] b;
    b   = 8'h00;
    pos = int'(slot) - HDR;
    if (pos < 0) begin
      b = HEADER_BYTE;
    end else begin
      if (MSB_FIRST != 0) begin
        pos = NBYTES - 1 - pos;
      end
      for (int k = 0; k < NBYTES; k++) begin
        if (k == pos) begin
          b = word[k*8 +: 8];
        end
      end
    end
    return b;
  endfunction

  // A dropped strobe has to be flagged in the very cycle it is presented,
  // so this flag is decoded directly from the registered in_ready.
  assign overrun = data_valid & ~in_ready;

  // Sticky record of any dropped word; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_sticky <= 1'b0;
    end else if (overrun) begin
      overrun_sticky <= 1'b1;
    end else begin
      overrun_sticky <= overrun_sticky;
    end
  end

  // Transmit sequencer with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      TxD_start <= 1'b0;
      TxD_data  <= 8'h00;
      word_done <= 1'b0;
      hold      <= {PAD_W{1'b0}};
      idx       <= {IDX_W{1'b0}};
      cnt       <= {CNT_W{1'b0}};
    end else begin
      TxD_start <= 1'b0;
      word_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (data_valid) begin
            hold     <= PAD_W'(data_in);
            in_ready <= 1'b0;
            state    <= S_LOAD;
          end else begin
            in_ready <= 1'b1;
          end
        end
        S_LOAD: begin
          TxD_data <= pick_byte(hold, idx);
          state    <= S_WAIT_FREE;
        end
        S_WAIT_FREE: begin
          if (TxD_busy) begin
            state <= S_WAIT_FREE;
          end else begin
            TxD_start <= 1'b1;
            state     <= S_START;
          end
        end
        S_START: begin
          cnt   <= {CNT_W{1'b0}};
          state <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (TxD_busy) begin
            state <= S_WAIT_DONE;
          end else if (cnt == CNT_LAST) begin
            // No acknowledge inside the window: assume the byte went out.
            word_done <= (idx == LAST_IDX);
            state     <= S_NEXT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_WAIT_DONE: begin
          if (TxD_busy) begin
            state <= S_WAIT_DONE;
          end else begin
            word_done <= (idx == LAST_IDX);
            state     <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (idx == LAST_IDX) begin
            idx      <= {IDX_W{1'b0}};
            in_ready <= 1'b1;
            state    <= S_IDLE;
          end else begin
            idx   <= idx + IDX_W'(1);
            state <= S_LOAD;
          end
        end
        default: begin
          idx      <= {IDX_W{1'b0}};
          in_ready <= 1'b1;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trn_word_serializer.sv
// Self-checking bench for trn_word_serializer: two instances (16-bit
// LSB-first and 20-bit MSB-first) driven by small UART busy models, checked
// every cycle against a schedule-based model, plus literal expectations.
module tb_trn_word_serializer;

  localparam int AT_A = 15;
  localparam int AT_B = 6;
`ifdef TRN_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam logic [7:0] HB_A = 8'h5A;
  localparam logic [7:0] HB_B = 8'hA5;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  dv;
  logic [15:0] din_a;
  logic [19:0] din_b;
  logic [1:0]  busy, rdy, start, done, ovr, stk;
  logic [7:0]  txd_a, txd_b;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int busy_len [2];
  int ucnt     [2] = '{0, 0};
  int acc;

  // model state (written only by the compare process)
  bit         m_on = 1'b0;
  bit         m_busy [2];
  bit         m_stk  [2];
  int         m_s0   [2];
  int         m_step [2];
  int         m_done [2];
  int         m_n    [2];
  logic [7:0] m_byte [2][4];
  logic [7:0] m_txd  [2];

  // observation logs (written only by the compare process)
  logic [7:0] obs_b [2][128];
  int         obs_c [2][128];
  int         obs_n [2] = '{0, 0};
  int         obs_dn[2] = '{0, 0};
  int         obs_dc[2] = '{0, 0};
  int         obs_ov[2] = '{0, 0};

  trn_word_serializer #(.WORD_W(16), .MSB_FIRST(0), .ACK_TIMEOUT(AT_A), .HEADER_BYTE(HB_A)) dut_a (
    .clk(clk), .rst(rst), .data_in(din_a), .data_valid(dv[0]), .in_ready(rdy[0]),
    .TxD_busy(busy[0]), .TxD_start(start[0]), .TxD_data(txd_a), .word_done(done[0]),
    .overrun(ovr[0]), .overrun_sticky(stk[0]));

  trn_word_serializer #(.WORD_W(20), .MSB_FIRST(1), .ACK_TIMEOUT(AT_B), .HEADER_BYTE(HB_B)) dut_b (
    .clk(clk), .rst(rst), .data_in(din_b), .data_valid(dv[1]), .in_ready(rdy[1]),
    .TxD_busy(busy[1]), .TxD_start(start[1]), .TxD_data(txd_b), .word_done(done[1]),
    .overrun(ovr[1]), .overrun_sticky(stk[1]));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // UART models: busy for busy_len cycles after each start (0 = never busy)
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (start[u] === 1'b1 && busy_len[u] > 0) ucnt[u] <= busy_len[u];
      else if (ucnt[u] > 0) ucnt[u] <= ucnt[u] - 1;
    end
  end
  assign busy[0] = (ucnt[0] > 0);
  assign busy[1] = (ucnt[1] > 0);

  function automatic int nbytes(int u);
    return (u == 0) ? 2 : 3;
  endfunction

  function automatic int gapc(int u, int bl);
    if (bl > 0) return bl + 2;
    return ((u == 0) ? AT_A : AT_B) + 1;
  endfunction

  function automatic logic [7:0] model_byte(int u, logic [31:0] v, int slot);
    int p, sh;
    logic [31:0] w;
    p = slot - HDR;
    if (p < 0) return (u == 0) ? HB_A : HB_B;
    w  = (u == 0) ? (v & 32'h0000_FFFF) : (v & 32'h000F_FFFF);
    sh = (u == 1) ? 8 * (nbytes(u) - 1 - p) : 8 * p;
    return 8'((w >> sh) & 32'hFF);
  endfunction

  task automatic chk(string nm, int u, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s u%0d cyc=%0d got=%02h want=%02h", nm, u, cyc, act, exp);
    end
  endtask

  task automatic pin(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic pin_bytes(string nm, int u, int base, int n,
                           logic [7:0] e0, logic [7:0] e1, logic [7:0] e2, logic [7:0] e3);
    logic [7:0] e;
    pin({nm, " starts"}, obs_n[u] - base, n);
    for (int i = 0; i < n && i < 4; i++) begin
      e = (i == 0) ? e0 : (i == 1) ? e1 : (i == 2) ? e2 : e3;
      chk({nm, " byte"}, u, obs_b[u][(base + i) % 128], e);
    end
  endtask

  // compare process: every cycle, DUT outputs against the model schedule
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      bit         wb, es, ed, eo;
      int         k, g, st, n;
      logic [7:0] eb, at;
      logic [31:0] v;
      at = (u == 0) ? txd_a : txd_b;
      wb = m_busy[u];
      es = 1'b0;
      eb = m_txd[u];
      if (m_on && wb && cyc >= m_s0[u]) begin
        k = (cyc - m_s0[u]) / m_step[u];
        if (((cyc - m_s0[u]) % m_step[u]) == 0 && k < m_n[u]) begin
          es = 1'b1;
          eb = m_byte[u][k];
        end
      end
      ed = wb && (cyc == m_done[u]);
      eo = (dv[u] == 1'b1) && wb;
      if (m_on) begin
        chk("in_ready", u, {7'd0, rdy[u]}, {7'd0, !wb});
        chk("TxD_start", u, {7'd0, start[u]}, {7'd0, es});
        chk("word_done", u, {7'd0, done[u]}, {7'd0, ed});
        chk("overrun", u, {7'd0, ovr[u]}, {7'd0, eo});
        chk("overrun_sticky", u, {7'd0, stk[u]}, {7'd0, m_stk[u]});
        if (es || !wb) chk("TxD_data", u, at, eb);
        if (start[u] === 1'b1) begin
          obs_b[u][obs_n[u] % 128] <= at;
          obs_c[u][obs_n[u] % 128] <= cyc;
          obs_n[u] <= obs_n[u] + 1;
        end
        if (done[u] === 1'b1) begin
          obs_dn[u] <= obs_dn[u] + 1;
          obs_dc[u] <= cyc;
        end
        if (ovr[u] === 1'b1) obs_ov[u] <= obs_ov[u] + 1;
        if (es) m_txd[u] <= eb;
        if (eo) m_stk[u] <= 1'b1;
        if (ed) m_busy[u] <= 1'b0;
        if (!wb && dv[u] == 1'b1) begin
          v  = (u == 0) ? {16'h0, din_a} : {12'h0, din_b};
          g  = gapc(u, busy_len[u]);
          st = g + 3;
          n  = nbytes(u) + HDR;
          m_busy[u] <= 1'b1;
          m_s0[u]   <= cyc + 3;
          m_step[u] <= st;
          m_n[u]    <= n;
          m_done[u] <= cyc + 3 + (n - 1) * st + g;
          for (int j = 0; j < 4; j++) m_byte[u][j] <= model_byte(u, v, j);
        end
      end
      if (rst === 1'b1) begin
        m_busy[u] <= 1'b0;
        m_stk[u]  <= 1'b0;
        m_txd[u]  <= 8'h00;
      end
    end
    if (rst === 1'b1) m_on <= 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(int limit);
    int n;
    n = 0;
    while ((m_busy[0] || m_busy[1]) && n < limit) begin
      tick();
      n++;
    end
    if (m_busy[0] || m_busy[1]) begin
      checks++;
      failures++;
      $display("FAIL wait_idle no completion within %0d cycles", limit);
    end
    repeat (2) tick();
  endtask

  initial begin
    int ba, bb, da, db;
    rst = 1'b1; dv = 2'b00; din_a = 16'h0; din_b = 20'h0;
    busy_len[0] = 10; busy_len[1] = 3;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    pin("reset in_ready a", int'(rdy[0]), 1);
    pin("reset TxD_data b", int'(txd_b), 0);

    // basic words on both units
    ba = obs_n[0]; bb = obs_n[1]; da = obs_dn[0]; db = obs_dn[1];
`ifdef TRN_HEADER_EN
    din_a = 16'h1234;
`else
    din_a = 16'hBEEF;
`endif
    din_b = 20'hABCDE; dv = 2'b11; acc = cyc;
    tick();
    dv = 2'b00;
    wait_idle(400);
`ifdef TRN_HEADER_EN
    pin_bytes("hdr word a", 0, ba, 3, 8'h5A, 8'h34, 8'h12, 8'h00);
    pin_bytes("hdr word b", 1, bb, 4, 8'hA5, 8'h0A, 8'hBC, 8'hDE);
`else
    pin_bytes("beef a", 0, ba, 2, 8'hEF, 8'hBE, 8'h00, 8'h00);
    pin_bytes("abcde b", 1, bb, 3, 8'h0A, 8'hBC, 8'hDE, 8'h00);
`endif
    pin("first start latency a", obs_c[0][ba % 128] - acc, 3);
    pin("word_done count a", obs_dn[0] - da, 1);
    pin("word_done count b", obs_dn[1] - db, 1);
    pin("in_ready after word a", int'(rdy[0]), 1);

    // UART never acknowledges: timeout path
    busy_len[0] = 0; busy_len[1] = 0;
    ba = obs_n[0]; bb = obs_n[1]; da = obs_dn[0];
    din_a = 16'h1357; din_b = 20'h24680; dv = 2'b11;
    tick();
    dv = 2'b00;
    wait_idle(400);
    pin("timeout done delay a", obs_dc[0] - obs_c[0][(obs_n[0] - 1) % 128], 16);
    pin("timeout done delay b", obs_dc[1] - obs_c[1][(obs_n[1] - 1) % 128], 7);
    pin("timeout word_done a", obs_dn[0] - da, 1);
    pin_bytes("timeout b", 1, bb, 3 + HDR,
              (HDR != 0) ? 8'hA5 : 8'h02, (HDR != 0) ? 8'h02 : 8'h46,
              (HDR != 0) ? 8'h46 : 8'h80, 8'h80);

    // second strobe 5 cycles into a transfer is dropped
    busy_len[0] = 10; busy_len[1] = 3;
    ba = obs_n[0]; da = obs_ov[0];
    din_a = 16'hC0DE; dv[0] = 1'b1;
    tick();
    dv[0] = 1'b0;
    repeat (4) tick();
    din_a = 16'hFFFF; dv[0] = 1'b1;
    tick();
    dv[0] = 1'b0;
    wait_idle(400);
    pin("overrun pulses a", obs_ov[0] - da, 1);
    pin("overrun_sticky a", int'(stk[0]), 1);
    pin_bytes("overrun a", 0, ba, 2 + HDR,
              (HDR != 0) ? 8'h5A : 8'hDE, (HDR != 0) ? 8'hDE : 8'hC0, 8'hC0, 8'h00);

    // strobe held high: back-to-back acceptance only from IDLE
    busy_len[1] = 1;
    db = obs_dn[1]; bb = obs_ov[1];
    din_b = 20'h13579; dv[1] = 1'b1;
    repeat (40) tick();
    dv[1] = 1'b0;
    wait_idle(400);
    pin("back-to-back words b", obs_dn[1] - db, (HDR != 0) ? 2 : 3);
    pin("back-to-back overruns b", obs_ov[1] - bb, (HDR != 0) ? 38 : 37);

    // reset during WAIT_DONE of the first byte
    busy_len[0] = 10;
    ba = obs_n[0]; da = obs_dn[0];
    din_a = 16'h55AA; dv[0] = 1'b1;
    tick();
    dv[0] = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pin("post-reset in_ready a", int'(rdy[0]), 1);
    pin("post-reset sticky a", int'(stk[0]), 0);
    pin("post-reset TxD_data a", int'(txd_a), 0);
    repeat (30) tick();
    pin("starts around reset a", obs_n[0] - ba, 1);
    pin("no word_done after reset a", obs_dn[0] - da, 0);
    ba = obs_n[0];
    din_a = 16'h0102; dv[0] = 1'b1;
    tick();
    dv[0] = 1'b0;
    wait_idle(400);
    pin_bytes("after reset a", 0, ba, 2 + HDR,
              (HDR != 0) ? 8'h5A : 8'h02, (HDR != 0) ? 8'h02 : 8'h01, 8'h01, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
